// File: rtl/mb_ext_mem_writer.sv
// Macroblock writer: collects one 4:2:0 macroblock (96 words) into a ping-pong buffer and
// drains it as 32 row bursts to the frame buffer and, in parallel, the display buffer.
module mb_ext_mem_writer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena_i,
    input  logic              pix_wr_i,
    input  logic [6:0]        pix_addr_i,
    input  logic [DATA_W-1:0] pix_data_i,
    input  logic              mb_done_i,
    output logic              mb_done_ready_o,
    input  logic [7:0]        mb_x_i,
    input  logic [7:0]        mb_y_i,
    input  logic [7:0]        pic_width_in_mbs_i,
    input  logic [7:0]        pic_height_in_mbs_i,
    input  logic [ADDR_W-1:0] frame_base_i,
    input  logic [ADDR_W-1:0] disp_base_i,
    output logic              ext_mem_writer_burst_o,
    output logic [4:0]        ext_mem_writer_burst_len_minus1_o,
    input  logic              ext_mem_writer_ready_i,
    output logic [ADDR_W-1:0] ext_mem_writer_addr_o,
    output logic [ADDR_W-1:0] ext_mem_writer_display_buf_addr_o,
    output logic [DATA_W-1:0] ext_mem_writer_data_o,
    output logic              ext_mem_writer_wr_o,
    output logic              busy_o,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_BURST = 3'd2,
        ST_DATA  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    state_t            state_q;
    logic [1:0]        full_q, full_d;
    logic              fill_bank_q;
    logic              drain_bank_q;
    logic [7:0]        ctx_x_q [2];
    logic [7:0]        ctx_y_q [2];
    logic [ADDR_W-1:0] ctx_fb_q [2];
    logic [ADDR_W-1:0] ctx_db_q [2];
    logic [4:0]        burst_idx_q;
    logic [1:0]        beat_q;
    logic [6:0]        rd_ptr_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [DATA_W-1:0] mem_q [0:191];

    logic              burst_q, wr_q;
    logic [4:0]        len_q;
    logic [ADDR_W-1:0] addr_q, daddr_q;
    logic [DATA_W-1:0] data_q;

    logic              accept, consume, last_beat, drain_done, wr_en, rd_en;
    logic [7:0]        wr_idx, rd_idx;
    logic [4:0]        nb;
    logic [ADDR_W-1:0] w_pix, s_pix, row, off;

    assign mb_done_ready_o = !(full_q[0] && full_q[1]);
    assign accept          = ena_i && mb_done_i && mb_done_ready_o;

    // Hub handshake: a word transfers on a cycle where wr and ready are both high; while
    // ready is low, wr and data are held unchanged. The burst pulse precedes the first word.
    assign consume    = wr_q && ext_mem_writer_ready_i;
    assign last_beat  = (beat_q == len_q[1:0]);
    assign drain_done = (state_q == ST_GAP) && (burst_idx_q == 5'd31);

    assign wr_idx = fill_bank_q  ? 8'(pix_addr_i) + 8'd96 : 8'(pix_addr_i);
    assign rd_idx = drain_bank_q ? 8'(rd_ptr_q) + 8'd96   : 8'(rd_ptr_q);
    assign wr_en  = ena_i && pix_wr_i && !full_q[fill_bank_q] && (pix_addr_i < 7'd96);
    assign rd_en  = ena_i && (rd_ptr_q < 7'd96) &&
                    ((state_q == ST_LOAD) ||
                     (state_q == ST_BURST && burst_idx_q == 5'd0) ||
                     (state_q == ST_DATA && consume));

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= pix_data_i;
        if (rd_en) rd_data_q <= mem_q[rd_idx];
    end

    always_comb begin
        full_d = full_q;
        if (drain_done) full_d[drain_bank_q] = 1'b0;
        if (accept)     full_d[fill_bank_q]  = 1'b1;
    end

    // Start address of the burst about to be issued; drain order is luma rows, Cb rows, Cr rows.
    always_comb begin
        nb    = (state_q == ST_LOAD) ? 5'd0 : burst_idx_q + 5'd1;
        w_pix = ADDR_W'(pic_width_in_mbs_i) << 4;
        s_pix = w_pix * (ADDR_W'(pic_height_in_mbs_i) << 4);
        row   = '0;
        off   = '0;
        if (!nb[4]) begin
            row = (ADDR_W'(ctx_y_q[drain_bank_q]) << 4) + ADDR_W'(nb[3:0]);
            off = row * w_pix + (ADDR_W'(ctx_x_q[drain_bank_q]) << 4);
        end else begin
            row = (ADDR_W'(ctx_y_q[drain_bank_q]) << 3) + ADDR_W'(nb[2:0]);
            off = s_pix + row * (w_pix >> 1) + (ADDR_W'(ctx_x_q[drain_bank_q]) << 3);
            if (nb[3]) off = off + (s_pix >> 2);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ctx_x_q[i]  <= '0;
                ctx_y_q[i]  <= '0;
                ctx_fb_q[i] <= '0;
                ctx_db_q[i] <= '0;
            end
        end else if (accept) begin
            ctx_x_q[fill_bank_q]  <= mb_x_i;
            ctx_y_q[fill_bank_q]  <= mb_y_i;
            ctx_fb_q[fill_bank_q] <= frame_base_i;
            ctx_db_q[fill_bank_q] <= disp_base_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            full_q       <= '0;
            fill_bank_q  <= 1'b0;
            drain_bank_q <= 1'b0;
            burst_idx_q  <= '0;
            beat_q       <= '0;
            rd_ptr_q     <= '0;
            burst_q      <= 1'b0;
            wr_q         <= 1'b0;
            len_q        <= '0;
            addr_q       <= '0;
            daddr_q      <= '0;
            data_q       <= '0;
        end else if (ena_i) begin
            full_q <= full_d;
            if (accept) fill_bank_q <= ~fill_bank_q;
            case (state_q)
                ST_IDLE: begin
                    rd_ptr_q    <= '0;
                    burst_idx_q <= '0;
                    if (full_q[drain_bank_q] || (accept && fill_bank_q == drain_bank_q))
                        state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    rd_ptr_q <= rd_ptr_q + 7'd1;
                    burst_q  <= 1'b1;
                    addr_q   <= ctx_fb_q[drain_bank_q] + off;
                    daddr_q  <= ctx_db_q[drain_bank_q] + off;
                    len_q    <= nb[4] ? 5'd1 : 5'd3;
                    beat_q   <= '0;
                    state_q  <= ST_BURST;
                end
                ST_BURST: begin
                    burst_q <= 1'b0;
                    wr_q    <= 1'b1;
                    state_q <= ST_DATA;
                    // First burst moves the prefetched word into the output register.
                    if (burst_idx_q == 5'd0) begin
                        data_q   <= rd_data_q;
                        rd_ptr_q <= rd_ptr_q + 7'd1;
                    end
                end
                ST_DATA: begin
                    if (consume) begin
                        data_q   <= rd_data_q;
                        rd_ptr_q <= rd_ptr_q + 7'd1;
                        beat_q   <= beat_q + 2'd1;
                        if (last_beat) begin
                            wr_q    <= 1'b0;
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (burst_idx_q == 5'd31) begin
                        drain_bank_q <= ~drain_bank_q;
                        state_q      <= ST_IDLE;
                    end else begin
                        burst_idx_q <= nb;
                        burst_q     <= 1'b1;
                        addr_q      <= ctx_fb_q[drain_bank_q] + off;
                        daddr_q     <= ctx_db_q[drain_bank_q] + off;
                        len_q       <= nb[4] ? 5'd1 : 5'd3;
                        beat_q      <= '0;
                        state_q     <= ST_BURST;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ext_mem_writer_burst_o            = burst_q;
    assign ext_mem_writer_burst_len_minus1_o = len_q;
    assign ext_mem_writer_addr_o             = addr_q;
    assign ext_mem_writer_display_buf_addr_o = daddr_q;
    assign ext_mem_writer_data_o             = data_q;
    assign ext_mem_writer_wr_o               = wr_q;
    assign busy_o                            = (state_q != ST_IDLE);
    assign dbg_state_o                       = state_q;

endmodule
